// File: rtl/j1_boot_loader.sv
// Boot sequencer for the j1: owns the core reset and multiplexes RAM port B
// between the running core and a host word stream that loads a new image.
//
// state   | meaning
// HALT    | core held in reset for one cycle so any j1 write retires
// LOAD    | accepting host words into RAM from base
// RELEASE | load finished; core held in reset for RESET_CYCLES cycles
// RUN     | j1 drives port B directly, core out of reset
module j1_boot_loader #(
  parameter int LOG2ABITS    = 13,
  parameter int DWIDTH       = 16,
  parameter int BOOT_HOLD    = 1,
  parameter int RESET_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 resetq,
  input  logic                 start_load,
  input  logic [LOG2ABITS-1:0] load_base,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DWIDTH-1:0]    s_data,
  input  logic                 s_last,
  input  logic [LOG2ABITS-1:0] j1_mem_addr,
  input  logic                 j1_mem_wr,
  input  logic [DWIDTH-1:0]    j1_dout,
  output logic [LOG2ABITS-1:0] mem_addr,
  output logic                 mem_wr,
  output logic [DWIDTH-1:0]    mem_dout,
  output logic                 cpu_reset,
  output logic                 done,
  output logic                 err,
  output logic [LOG2ABITS:0]   word_count,
  output logic [DWIDTH-1:0]    checksum
);

  localparam logic [1:0] S_HALT    = 2'd0;
  localparam logic [1:0] S_LOAD    = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;
  localparam logic [1:0] S_RUN     = 2'd3;
  localparam logic [1:0] S_RESET   = (BOOT_HOLD != 0) ? S_HALT : S_RELEASE;

  localparam logic [7:0]         RCNT_INIT = 8'(RESET_CYCLES);
  localparam logic [LOG2ABITS:0] CNT_ONE   = (LOG2ABITS+1)'(1);

  logic [1:0]           state;
  logic [LOG2ABITS-1:0] base;
  logic [LOG2ABITS:0]   cnt;
  logic [LOG2ABITS:0]   addr_sum;
  logic [7:0]           rcnt;
  logic [DWIDTH-1:0]    csum;
  logic                 err_q;
  logic                 done_q;
  logic                 hs;
  logic                 drop;

  // The extra sum bit is the carry that flags a write past the top of RAM.
  assign addr_sum = {1'b0, base} + cnt;
  assign hs       = s_valid && (state == S_LOAD);
  assign drop     = addr_sum[LOG2ABITS] | err_q;

  assign cpu_reset  = (state != S_RUN);
  assign s_ready    = (state == S_LOAD);
  assign done       = done_q;
  assign err        = err_q;
  assign word_count = cnt;
  assign checksum   = csum;

  always_comb begin
    mem_addr = addr_sum[LOG2ABITS-1:0];
    mem_wr   = 1'b0;
    mem_dout = s_data;
    if (state == S_RUN) begin
      mem_addr = j1_mem_addr;
      mem_wr   = j1_mem_wr;
      mem_dout = j1_dout;
    end else if (hs && !drop) begin
      mem_wr = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state  <= S_RESET;
      base   <= '0;
      cnt    <= '0;
      rcnt   <= '0;
      csum   <= '0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_RUN: begin
          if (start_load) begin
            base  <= load_base;
            cnt   <= '0;
            csum  <= '0;
            err_q <= 1'b0;
            state <= S_HALT;
          end
        end
        S_HALT: state <= S_LOAD;
        S_LOAD: begin
          if (hs) begin
            if (drop) begin
              err_q <= 1'b1;
            end else begin
              cnt  <= cnt + CNT_ONE;
              csum <= csum + s_data;
            end
            if (s_last) begin
              rcnt  <= RCNT_INIT;
              state <= S_RELEASE;
            end
          end
        end
        default: begin
          // rcnt of 0 only occurs straight out of reset with BOOT_HOLD=0.
          if (rcnt <= 8'd1) begin
            rcnt   <= '0;
            done_q <= 1'b1;
            state  <= S_RUN;
          end else begin
            rcnt <= rcnt - 8'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/j1_boot_loader.md
Name: j1_boot_loader

Overview:
- Sequencer that owns the j1 reset and shares RAM data port B between the j1 core and a host word stream (UART/JTAG bridge).
- In RUN, the j1 drives port B transparently.
- On a load command it holds the j1 in reset and streams words into RAM from a base address. It then releases the core after a fixed reset-hold interval.
- Sits between the j1 instance, the shared dual-port RAM and the host bridge.

Parameters:
- LOG2ABITS, 13, RAM word-address width (8k words).
- DWIDTH, 16, data word width.
- BOOT_HOLD, 1, 1 = load to base 0 after power-on before the first run; 0 = run immediately after the reset hold.
- RESET_CYCLES, 4, cycles cpu_reset stays high in RELEASE (1..255).

Ports:
- clk  in  1  system clock.
- resetq  in  1  asynchronous active-low reset.
- start_load  in  1  one-cycle load request; honoured only in RUN.
- load_base  in  LOG2ABITS  first word address; sampled with start_load.
- s_valid  in  1  host word valid.
- s_ready  out  1  loader accepts a word.
- s_data  in  DWIDTH  host word.
- s_last  in  1  marks the final word of the image.
- j1_mem_addr  in  LOG2ABITS  j1 data address.
- j1_mem_wr  in  1  j1 write strobe.
- j1_dout  in  DWIDTH  j1 write data.
- mem_addr  out  LOG2ABITS  RAM port B address.
- mem_wr  out  1  RAM port B write enable.
- mem_dout  out  DWIDTH  RAM port B write data.
- cpu_reset  out  1  active-high reset to the j1.
- done  out  1  one-cycle pulse when the core leaves reset after a load.
- err  out  1  sticky overflow flag; cleared by the next accepted start_load.
- word_count  out  LOG2ABITS+1  words written in the current/last load.
- checksum  out  DWIDTH  modulo-2^DWIDTH sum of words written.

Behaviour:
- State machine states: HALT, LOAD, RELEASE, RUN.
- Reset values while resetq is low:
  - state = HALT if BOOT_HOLD=1, else RELEASE.
  - base = 0, cnt = 0, rcnt = 0.
  - cpu_reset = 1, s_ready = 0, mem_wr = 0, done = 0, err = 0, word_count = 0, checksum = 0.
- Output decoding:
  - cpu_reset = 1 in every state except RUN; decoded from the state register.
  - s_ready = 1 only in LOAD.
- RUN:
  - mem_addr = j1_mem_addr, mem_wr = j1_mem_wr, mem_dout = j1_dout (combinational, zero latency).
  - start_load=1 → latch base = load_base; clear cnt, err, checksum; go to HALT.
- HALT:
  - Exactly one cycle with cpu_reset = 1 and mem_wr = 0, so any j1 write in progress retires; then go to LOAD.
- LOAD:
  - The handshake fires on a cycle with s_valid & s_ready.
  - On each handshake: mem_addr = base + cnt (LOG2ABITS bits), mem_dout = s_data, mem_wr = 1 in the same cycle.
  - Also on each handshake: cnt += 1 and checksum += s_data.
  - No handshake → mem_wr = 0; mem_addr still shows base + cnt.
- Overflow:
  - A handshake with base + cnt ≥ 2^LOG2ABITS (carry out of the address add) sets err.
  - That word is dropped: mem_wr = 0, cnt and checksum unchanged.
  - All later words are also dropped until s_last; there is no wrap to address 0.
- End of image:
  - Handshake with s_last = 1 → go to RELEASE and load rcnt = RESET_CYCLES.
  - The last word is written (or dropped) by the same rules.
- RELEASE:
  - mem_wr = 0; rcnt decrements each cycle.
  - rcnt == 1 → next state RUN, with done = 1 in that first RUN cycle.
  - cpu_reset is therefore high for exactly RESET_CYCLES cycles in RELEASE.
- Status outputs:
  - word_count = cnt.
  - Both word_count and checksum hold their values in RUN until the next start_load.
- Ignored inputs:
  - start_load outside RUN is ignored.
  - s_valid outside LOAD is ignored (s_ready = 0).
- resetq asserted mid-load:
  - Immediately aborts to the reset state; partially written RAM contents are left as they are.
  - With BOOT_HOLD=1 the load restarts at base 0.
- Width rules:
  - cnt, and the base + cnt sum used for the overflow check, are LOG2ABITS+1 bits.
  - checksum wraps modulo 2^DWIDTH.

Test Plan:
- BOOT_HOLD=1, release resetq, stream 0x1111, 0x2222, 0x3333 (last) with s_valid continuous:
  - writes to addresses 0, 1, 2 on consecutive cycles;
  - word_count = 3, checksum = 0x6666;
  - cpu_reset falls exactly 4 cycles after the last beat, with done high for one cycle.
- In RUN, drive j1_mem_addr = 0x0ABC, j1_mem_wr = 1, j1_dout = 0xBEEF:
  - mem_addr/mem_wr/mem_dout mirror them in the same cycle;
  - cpu_reset = 0.
- In RUN, pulse start_load with load_base = 0x100, then send 2 words with s_valid gaps of 3 cycles:
  - cpu_reset rises the next cycle, one HALT cycle with mem_wr = 0 follows;
  - mem_wr pulses only on handshake cycles, at 0x100 and 0x101.
- load_base = 0x1FFE, send 4 words (last on the 4th):
  - 0x1FFE and 0x1FFF are written;
  - words 3 and 4 are accepted with mem_wr = 0;
  - err = 1, word_count = 2;
  - err clears on the next start_load.
- Pulse start_load during LOAD and during RELEASE:
  - no effect on base, cnt or state timing.
- Assert resetq mid-LOAD after 5 words:
  - all outputs go to reset values asynchronously;
  - with BOOT_HOLD=1 the next word after release is written to address 0.
